// File: rtl/data_memory_hs_pkg.sv
// Shared definitions for the handshaked data memory.
//   - access size encodings (req_size)
//   - FSM state encoding
//   - MAX_LATENCY bound for the LATENCY parameter
//   - helpers for alignment, byte-lane enables and load extension
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;  // 2'b11 is also treated as a word

  localparam int MAX_LATENCY = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Half accesses need an even address; word accesses need a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lo[0];
      default:   return lo != 2'b00;
    endcase
  endfunction

  // Little-endian lane enables: lane i holds bits [8i+7:8i] of the word.
  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << lo;
      SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  // Pick the addressed lane(s) out of a stored word and extend them to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0] size, input logic [1:0] lo,
                                              input logic sgn, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return {{24{sgn & b[7]}}, b};
      SIZE_HALF: return {{16{sgn & h[15]}}, h};
      default:   return word;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_hs_mem_array.sv
// Synchronous single-port RAM, DEPTH_WORDS x 32, four byte-lane write enables.
//   clk    rising-edge clock
//   en     access strobe: registers the read word and allows writes
//   we     per-lane write enables (lane i = bits [8i+7:8i])
//   index  word index
//   wdata  write data, already placed in its lanes
//   rdata  registered read data (pre-write contents on a write)
module mem_array #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: the storage array has no reset; clearing a RAM needs one write per
  // word and would stop it mapping onto block memory.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/data_memory_hs.sv
// Data memory with valid/ready request handshake and fixed access latency.
// Byte/half/word loads and stores, little-endian lanes, sign/zero extension,
// misaligned requests answered with a flag and no effect.
//   clk, rst     clock and asynchronous active-high reset
//   req_valid    request present;  req_ready  request accepted when both high
//   req_write    1 = store;  req_size  00 byte, 01 half, 1x word
//   req_signed   sign-extend byte/half loads
//   address      byte address (wraps modulo DEPTH_WORDS*4)
//   writeData    store data, right-aligned
//   resp_valid   one-cycle response pulse
//   readData     load result during the response, otherwise 0
//   misaligned   response flag for a rejected misaligned access
module data_memory_hs
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  misaligned
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t             state, state_d;
  logic [3:0]         cnt;
  logic               write_q, signed_q, mis_q;
  logic [1:0]         size_q, lo_q;
  logic [IDX_W-1:0]   index_q;
  logic [31:0]        wdata_q;

  logic               accept, access;
  logic               ram_en;
  logic [3:0]         ram_we;
  logic [31:0]        ram_wdata, ram_rdata;

  // Address bits above the word index are deliberately ignored (wrap-around).
  logic unused_addr;
  assign unused_addr = ^address[ADDR_WIDTH-1:IDX_W+2];

  assign accept = (state == IDLE) && req_valid;
  assign access = (state == BUSY) && (cnt == 4'd0);

  // State register plus the request latched at acceptance.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      mis_q    <= 1'b0;
      size_q   <= SIZE_BYTE;
      lo_q     <= 2'b00;
      index_q  <= '0;
      wdata_q  <= 32'd0;
    end else begin
      state <= state_d;
      if (accept) begin
        cnt      <= CNT_INIT;
        write_q  <= req_write;
        signed_q <= req_signed;
        mis_q    <= is_misaligned(req_size, address[1:0]);
        size_q   <= req_size;
        lo_q     <= address[1:0];
        index_q  <= address[IDX_W+1:2];
        wdata_q  <= writeData[31:0];
      end else if ((state == BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Next-state logic. A misaligned request skips BUSY so it never touches the array.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid) state_d = is_misaligned(req_size, address[1:0]) ? RESP : BUSY;
      BUSY:    if (cnt == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs and array controls. A reset during BUSY drops state to IDLE
  // before the access edge, so an in-flight store is never committed.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    misaligned = (state == RESP) && mis_q;
    readData   = '0;
    if ((state == RESP) && !mis_q && !write_q)
      readData = load_extend(size_q, lo_q, signed_q, ram_rdata);

    ram_en = access;
    ram_we = (access && write_q) ? lane_enables(size_q, lo_q) : 4'b0000;
    case (size_q)
      SIZE_BYTE: ram_wdata = {4{wdata_q[7:0]}};
      SIZE_HALF: ram_wdata = {2{wdata_q[15:0]}};
      default:   ram_wdata = wdata_q;
    endcase
  end

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .index (index_q),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_data_memory_hs.sv
// Directed bench for data_memory_hs. Three instances share the request inputs:
//   [0] DEPTH_WORDS=1024, LATENCY=2   (main)
//   [1] DEPTH_WORDS=16,   LATENCY=2   (wrap)
//   [2] DEPTH_WORDS=16,   LATENCY=1   (wrap, minimum latency)
module tb_data_memory_hs;
  import mem_pkg::*;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] address, write_data;

  logic        req_ready_a  [N];
  logic        resp_valid_a [N];
  logic        mis_a        [N];
  logic [31:0] rd_a         [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_hs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[0]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .address(address), .writeData(write_data), .resp_valid(resp_valid_a[0]),
    .readData(rd_a[0]), .misaligned(mis_a[0]));

  data_memory_hs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(16), .LATENCY(2)) dut_w2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[1]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .address(address), .writeData(write_data), .resp_valid(resp_valid_a[1]),
    .readData(rd_a[1]), .misaligned(mis_a[1]));

  data_memory_hs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(16), .LATENCY(1)) dut_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_a[2]),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .address(address), .writeData(write_data), .resp_valid(resp_valid_a[2]),
    .readData(rd_a[2]), .misaligned(mis_a[2]));

  function automatic int lat_of(input int sel);
    return (sel == 2) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance sel: accept, wait for the response
  // (bounded), check latency and result, then check the pulse ends and
  // req_ready is back.
  task automatic xfer(input int sel, input string tag, input logic wr, input logic [1:0] sz,
                      input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_mis);
    int k;
    int exp_lat;
    exp_lat = exp_mis ? 0 : lat_of(sel);
    @(negedge clk);
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    address    = addr;
    write_data = wd;
    req_valid  = 1'b1;
    check({tag, "/ready_before"}, {31'b0, req_ready_a[sel]}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    while (!resp_valid_a[sel] && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "/latency"}, 32'(k), 32'(exp_lat));
    check({tag, "/readData"}, rd_a[sel], exp_rd);
    check({tag, "/misaligned"}, {31'b0, mis_a[sel]}, {31'b0, exp_mis});
    @(posedge clk); #1;
    check({tag, "/pulse_end"}, {31'b0, resp_valid_a[sel]}, 32'd0);
    check({tag, "/readData_idle"}, rd_a[sel], 32'd0);
    check({tag, "/ready_after"}, {31'b0, req_ready_a[sel]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          acc_cyc[$];
    logic [31:0] resp_q[$];
    logic [31:0] b2b_addr [3];
    bit          acc;
    int          nacc;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SIZE_WORD;
    req_signed = 1'b0; address = 32'd0; write_data = 32'd0;

    // Reset state.
    #3;
    check("reset/ready", {31'b0, req_ready_a[0]}, 32'd1);
    check("reset/resp_valid", {31'b0, resp_valid_a[0]}, 32'd0);
    check("reset/readData", rd_a[0], 32'd0);
    check("reset/misaligned", {31'b0, mis_a[0]}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // 1. Reset mid-BUSY aborts a store.
    xfer(0, "t1_init", 1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    req_write = 1'b1; req_size = SIZE_WORD; address = 32'h10; write_data = 32'hDEADBEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;            // E0: accepted
    req_valid = 1'b0;
    @(posedge clk); #1;            // E1: still busy, access would be at E2
    check("t1/busy_not_ready", {31'b0, req_ready_a[0]}, 32'd0);
    rst = 1'b1;
    #1;
    check("t1/rst_ready", {31'b0, req_ready_a[0]}, 32'd1);
    check("t1/rst_resp_valid", {31'b0, resp_valid_a[0]}, 32'd0);
    check("t1/rst_readData", rd_a[0], 32'd0);
    check("t1/rst_misaligned", {31'b0, mis_a[0]}, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t1/no_late_resp", {31'b0, resp_valid_a[0]}, 32'd0);
    xfer(0, "t1_load", 1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    // 2. Word store then word load.
    xfer(0, "t2_store", 1'b1, SIZE_WORD, 1'b0, 32'h0, 32'hAABBCCDD, 32'h0, 1'b0);
    xfer(0, "t2_load",  1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'hAABBCCDD, 1'b0);

    // 3. Byte store into a word, then lane loads with both extensions.
    xfer(0, "t3_word",   1'b1, SIZE_WORD, 1'b0, 32'h4, 32'h11223344, 32'h0, 1'b0);
    xfer(0, "t3_byte",   1'b1, SIZE_BYTE, 1'b0, 32'h5, 32'h12345680, 32'h0, 1'b0);
    xfer(0, "t3_lb",     1'b0, SIZE_BYTE, 1'b1, 32'h5, 32'h0, 32'hFFFFFF80, 1'b0);
    xfer(0, "t3_lbu",    1'b0, SIZE_BYTE, 1'b0, 32'h5, 32'h0, 32'h00000080, 1'b0);
    xfer(0, "t3_lw",     1'b0, SIZE_WORD, 1'b0, 32'h4, 32'h0, 32'h11228044, 1'b0);
    xfer(0, "t3_lh_lo",  1'b0, SIZE_HALF, 1'b1, 32'h4, 32'h0, 32'hFFFF8044, 1'b0);
    xfer(0, "t3_lh_hi",  1'b0, SIZE_HALF, 1'b1, 32'h6, 32'h0, 32'h00001122, 1'b0);
    xfer(0, "t3_lbu_b3", 1'b0, SIZE_BYTE, 1'b0, 32'h7, 32'h0, 32'h00000011, 1'b0);
    xfer(0, "t3_sh",     1'b1, SIZE_HALF, 1'b0, 32'h2, 32'hFFFF1357, 32'h0, 1'b0);
    xfer(0, "t3_lw_sh",  1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'h1357CCDD, 1'b0);

    // 4. Misaligned accesses respond immediately and change nothing.
    xfer(0, "t4_lh_odd",  1'b0, SIZE_HALF, 1'b1, 32'h3, 32'h0, 32'h0, 1'b1);
    xfer(0, "t4_sw_mis",  1'b1, SIZE_WORD, 1'b0, 32'h6, 32'hCAFEF00D, 32'h0, 1'b1);
    xfer(0, "t4_lw_same", 1'b0, SIZE_WORD, 1'b0, 32'h4, 32'h0, 32'h11228044, 1'b0);

    // 5. req_valid held high across three requests.
    b2b_addr[0] = 32'h0; b2b_addr[1] = 32'h4; b2b_addr[2] = 32'h10;
    @(negedge clk);
    req_write = 1'b0; req_size = SIZE_WORD; req_signed = 1'b0;
    address = b2b_addr[0]; req_valid = 1'b1;
    nacc = 0;
    for (int c = 0; c < 16; c++) begin
      acc = req_ready_a[0] && req_valid;
      @(posedge clk); #1;
      if (resp_valid_a[0]) resp_q.push_back(rd_a[0]);
      if (acc) begin
        acc_cyc.push_back(c);
        nacc++;
        if (nacc < 3) address = b2b_addr[nacc];
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("t5/accepts", 32'(acc_cyc.size()), 32'd3);
    check("t5/gap01", (acc_cyc.size() > 1) ? 32'(acc_cyc[1] - acc_cyc[0]) : 32'hFFFFFFFF, 32'd4);
    check("t5/gap12", (acc_cyc.size() > 2) ? 32'(acc_cyc[2] - acc_cyc[1]) : 32'hFFFFFFFF, 32'd4);
    check("t5/responses", 32'(resp_q.size()), 32'd3);
    check("t5/rd0", (resp_q.size() > 0) ? resp_q[0] : 32'hXXXXXXXX, 32'h1357CCDD);
    check("t5/rd1", (resp_q.size() > 1) ? resp_q[1] : 32'hXXXXXXXX, 32'h11228044);
    check("t5/rd2", (resp_q.size() > 2) ? resp_q[2] : 32'hXXXXXXXX, 32'h00000000);

    // 6. Address wrap on 16-word arrays, LATENCY=2 and LATENCY=1.
    xfer(1, "t6_w2_store", 1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h5, 32'h0, 1'b0);
    xfer(1, "t6_w2_load",  1'b0, SIZE_WORD, 1'b0, 32'h0, 32'h0, 32'h5, 1'b0);
    xfer(2, "t6_w1_store", 1'b1, SIZE_WORD, 1'b0, 32'h44, 32'h7, 32'h0, 1'b0);
    xfer(2, "t6_w1_load",  1'b0, SIZE_WORD, 1'b0, 32'h4, 32'h0, 32'h7, 1'b0);
    xfer(2, "t6_w1_mis",   1'b0, SIZE_HALF, 1'b0, 32'h1, 32'h0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
